// File: rtl/tbus_arbiter.sv
// Round-robin arbiter for N requesters sharing one tristate bus.
// Optional grant hold limit enabled by defining TBUS_ARB_HOLD_LIMIT_EN.
module tbus_arbiter #(
  parameter int N       = 4,
  parameter int MAXHOLD = 8
) (
  input  logic                 CP,
  input  logic                 CD,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         E,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 BUSY
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   e_q, e_d;
  logic [W-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;

  logic [W-1:0]   pick;
  logic           found;
  logic           own;
  logic           preempt;
  logic [N-1:0]   others;
  logic [N-1:0]   one;

  assign one    = {{(N-1){1'b0}}, 1'b1};
  assign own    = |(REQ & e_q);
  assign others = REQ & ~e_q;

  // Round-robin winner: first set REQ bit after the last grant.
  always_comb begin
    int idx;
    pick  = gnt_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(gnt_q) + k) % N;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = W'(idx);
      end
    end
  end

`ifdef TBUS_ARB_HOLD_LIMIT_EN
  logic [7:0] cnt_q, cnt_d;

  // Completing this cycle would reach the limit while others wait.
  assign preempt = (cnt_q >= 8'(MAXHOLD - 1)) && (|others);

  // Hold counter register.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  // Clear on grant entry, count grant cycles, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != GRANT || state_d != GRANT) begin
      cnt_d = 8'd0;
    end else if (cnt_q < 8'(MAXHOLD)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
`else
  logic [7:0] unused_hold;

  assign unused_hold = 8'(MAXHOLD);
  assign preempt     = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= IDLE;
      e_q     <= '0;
      gnt_q   <= W'(N - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: grant, release through one turnaround cycle, go idle.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE, TURN: begin
        if (found) begin
          state_d = GRANT;
          e_d     = one << pick;
          gnt_d   = pick;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          e_d     = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (!own || preempt) begin
          state_d = TURN;
          e_d     = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        e_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign E      = e_q;
  assign GNT_ID = gnt_q;
  assign BUSY   = busy_q;

endmodule

// File: doc/tbus_arbiter.md
TBUS_ARBITER -- requirements
Module: tbus_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one tristate bus; legal range 2..16.
REQ-002 Parameter MAXHOLD, default 8: maximum consecutive grant cycles while another request is pending; legal range 1..255. Used only when TBUS_ARB_HOLD_LIMIT_EN is defined.
REQ-003 CP  input  1  clock; rising edge.
REQ-004 CD  input  1  reset; asynchronous, active-low.
REQ-005 REQ  input  N  per-requester bus request; level-sensitive.
REQ-006 E  output  N  per-requester tristate driver enable; drives the E pin of each requester's bufif1-style driver; at most one bit high.
REQ-007 GNT_ID  output  clog2(N)  index of the current or last granted requester.
REQ-008 BUSY  output  1  high while any E bit is high or a turnaround cycle is in progress.

Function
REQ-009 The block SHALL have three states: IDLE, GRANT and TURN.
REQ-010 E, GNT_ID and BUSY SHALL be registered outputs with no combinational path from REQ.
REQ-011 IDLE, with no REQ bit set: stay in IDLE; E=0 and BUSY=0.
REQ-012 IDLE, with any REQ bit set at edge t: go to GRANT; from edge t+1, E[g]=1, GNT_ID=g and BUSY=1 (one-cycle latency).
REQ-013 Selection SHALL be round-robin: g is the first set REQ bit searching upward from (last GNT_ID + 1) mod N, wrapping at N-1 to 0.
REQ-014 GRANT: hold E[g]=1 while REQ[g]=1 and no preemption condition (REQ-022) applies.
REQ-015 GRANT: when REQ[g]=0 is sampled, go to TURN; E becomes all zeros at the next edge.
REQ-016 TURN SHALL last exactly one cycle: E=0, BUSY=1, GNT_ID unchanged (break-before-make; no two drivers ever enabled in the same or adjacent cycles).
REQ-017 Leaving TURN: if any REQ bit is set, go to GRANT with a new round-robin selection per REQ-013; otherwise go to IDLE.
REQ-018 Back-to-back requests by the same requester SHALL still pass through TURN. It is re-granted only if it is the round-robin winner.
REQ-019 A REQ bit that rises and falls while another requester holds the grant SHALL be ignored; there is no request latching.
REQ-020 E SHALL never have more than one bit high in any cycle, including the reset release cycle.

Reset
REQ-021 While CD=0: state=IDLE, E=0, BUSY=0, GNT_ID=N-1 (first grant searches from 0), hold counter=0; all take effect immediately and asynchronously, including mid-grant.

Configuration
REQ-022 With TBUS_ARB_HOLD_LIMIT_EN defined:
- an 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle;
- when the counter reaches MAXHOLD while any other REQ bit is set, go to TURN even though REQ[g]=1;
- when no other request is pending, the counter saturates at MAXHOLD and the grant continues.
REQ-023 Without TBUS_ARB_HOLD_LIMIT_EN: no counter logic; the grant is held until REQ[g] falls; MAXHOLD is ignored.

Verification
REQ-024 Reset, then REQ=0001 at edge 1: E=0001, GNT_ID=0, BUSY=1 from edge 2; REQ=0000 at edge 5: E=0000 at edge 6 (TURN), BUSY=0 at edge 7.
REQ-025 REQ=1111 held, each requester dropping REQ after 3 granted cycles: grant order 0,1,2,3,0; exactly one all-zero E cycle between grants; E is never multi-hot.
REQ-026 REQ=0101 with GNT_ID=2 in TURN: next grant goes to requester 0 (wrap-around from 3 to 0).
REQ-027 Macro defined, MAXHOLD=4, REQ[0] held high, REQ[1] raised during the grant: E[0] stays high 4 cycles, then TURN, then E=0010. Macro undefined: E[0] stays high until REQ[0] falls.
REQ-028 CD pulsed low mid-GRANT between clock edges: E=0 and BUSY=0 immediately without a clock; after release with REQ=0010, the first grant goes to requester 1 one cycle later.
